// File: rtl/mips_op_codes_defines.sv
// Shared MIPS opcode constants and PCSource encodings for the multicycle datapath.
// Consumers: pc_ir_fetch_unit, control_module.
package mips_op_codes_defines;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pc_src_e;

endpackage

// File: rtl/en_reg.sv
// 32-bit register with load enable and asynchronous active-low clear.
module en_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_q <= 32'h0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pc_ir_fetch_unit.sv
// PC/IR/MDR/ALUOut register slice of a multicycle MIPS datapath with next-PC selection.
// Optional macro PC_BNE_EN inverts the branch condition for BNE.
module pc_ir_fetch_unit
    import mips_op_codes_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        IorD,
    input  logic [1:0]  PCSource,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [31:0] mem_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic [31:0] alu_out,
    output logic [5:0]  Op_code,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [31:0] imm_sext,
    output logic [31:0] jump_target
);

    logic        w_branch_taken;
    logic        w_pc_en;
    logic [31:0] w_pc_sel;
    logic [31:0] w_pc_next;
    logic [31:0] r_mdr;
    logic [31:0] r_alu_out;

    en_reg u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pc_en),
        .i_d  (w_pc_next),
        .o_q  (pc)
    );

    en_reg u_ir_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (IRWrite),
        .i_d  (mem_rdata),
        .o_q  (instr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mdr     <= 32'h0;
            r_alu_out <= 32'h0;
        end else begin
            r_mdr     <= mem_rdata;
            r_alu_out <= alu_result;
        end
    end

    assign mdr     = r_mdr;
    assign alu_out = r_alu_out;

    assign Op_code     = instr[31:26];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign funct       = instr[5:0];
    assign imm_sext    = {{16{instr[15]}}, instr[15:0]};
    assign jump_target = {pc[31:28], instr[25:0], 2'b00};

    assign mem_addr = IorD ? r_alu_out : pc;

`ifdef PC_BNE_EN
    assign w_branch_taken = (Op_code == BNE) ? ~alu_zero : alu_zero;
`else
    assign w_branch_taken = alu_zero;
`endif

    // HOLD select suppresses the write entirely, so PCWrite cannot disturb the PC.
    assign w_pc_en = (PCWrite | (PCWriteCond & w_branch_taken)) &&
                     (PCSource != PCSRC_HOLD);

    always_comb begin
        w_pc_sel = pc;
        case (PCSource)
            PCSRC_ALU:    w_pc_sel = alu_result;
            PCSRC_ALUOUT: w_pc_sel = r_alu_out;
            PCSRC_JUMP:   w_pc_sel = jump_target;
            default:      w_pc_sel = pc;
        endcase
    end

    assign w_pc_next = {w_pc_sel[31:2], 2'b00};

endmodule

// File: tb/tb_pc_ir_fetch_unit.sv
// Directed bench for pc_ir_fetch_unit; expectations are hand-computed per step.
// Honours PC_BNE_EN for the BNE branch expectation.
module tb_pc_ir_fetch_unit;

    logic        clk;
    logic        rst;
    logic        IRWrite, PCWrite, PCWriteCond, IorD;
    logic [1:0]  PCSource;
    logic [31:0] mem_rdata, alu_result;
    logic        alu_zero;
    logic [31:0] mem_addr, pc, instr, mdr, alu_out, imm_sext, jump_target;
    logic [5:0]  Op_code, funct;
    logic [4:0]  rs, rt, rd;

    int n_cmp = 0;
    int n_err = 0;

    pc_ir_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .PCSource    (PCSource),
        .mem_rdata   (mem_rdata),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .mem_addr    (mem_addr),
        .pc          (pc),
        .instr       (instr),
        .mdr         (mdr),
        .alu_out     (alu_out),
        .Op_code     (Op_code),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .funct       (funct),
        .imm_sext    (imm_sext),
        .jump_target (jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        IRWrite = 0; PCWrite = 0; PCWriteCond = 0; IorD = 0;
        PCSource = 2'b00; mem_rdata = '0; alu_result = '0; alu_zero = 0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_alu_out", alu_out, 32'h0);
        chk("rst_opcode", {26'h0, Op_code}, 32'h0);
        tick();
        rst = 1'b1;

        // Fetch LW with PC+4
        mem_rdata = 32'h8C220004; IRWrite = 1; PCWrite = 1; PCSource = 2'b00; alu_result = 32'h4;
        tick();
        chk("fetch_instr", instr, 32'h8C220004);
        chk("fetch_opcode", {26'h0, Op_code}, 32'h23);
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_imm", imm_sext, 32'h4);
        chk("fetch_rs", {27'h0, rs}, 32'h1);
        chk("fetch_rt", {27'h0, rt}, 32'h2);
        chk("fetch_rd", {27'h0, rd}, 32'h0);
        chk("fetch_funct", {26'h0, funct}, 32'h4);
        chk("fetch_mdr", mdr, 32'h8C220004);
        chk("fetch_alu_out", alu_out, 32'h4);

        // Memory address mux
        IRWrite = 0; alu_result = 32'h8;
        tick();
        chk("pc_8", pc, 32'h8);
        PCWrite = 0; alu_result = 32'h100;
        tick();
        chk("ir_hold", instr, 32'h8C220004);
        IorD = 1; #1;
        chk("mem_addr_aluout", mem_addr, 32'h100);
        IorD = 0; #1;
        chk("mem_addr_pc", mem_addr, 32'h8);

        // Low bits forced, wrap to zero
        PCWrite = 1; alu_result = 32'h13;
        tick();
        chk("pc_align", pc, 32'h10);
        alu_result = 32'hFFFFFFFC;
        tick();
        chk("pc_top", pc, 32'hFFFFFFFC);
        alu_result = 32'h0;
        tick();
        chk("pc_wrap", pc, 32'h0);

        // BEQ: load instr, alu_out = 0x40
        PCWrite = 0; IRWrite = 1; mem_rdata = 32'h10000000; alu_result = 32'h40;
        tick();
        chk("beq_opcode", {26'h0, Op_code}, 32'h4);
        IRWrite = 0; PCWriteCond = 1; PCSource = 2'b01; alu_zero = 1;
        tick();
        chk("beq_taken", pc, 32'h40);
        alu_zero = 0; alu_result = 32'h80;
        tick();
        chk("beq_not_taken", pc, 32'h40);

        // Hold select ignores PCWrite
        PCWriteCond = 0; PCWrite = 1; PCSource = 2'b11;
        tick();
        chk("pcsrc_hold", pc, 32'h40);

        // PCWrite dominates a failed branch condition
        PCWriteCond = 1; PCSource = 2'b01; alu_zero = 0;
        tick();
        chk("pcwrite_dominates", pc, 32'h80);

        // BNE behaviour depends on PC_BNE_EN
        PCWrite = 0; PCWriteCond = 0; IRWrite = 1; mem_rdata = 32'h14000000; alu_result = 32'hC0;
        tick();
        chk("bne_opcode", {26'h0, Op_code}, 32'h5);
        IRWrite = 0; PCWriteCond = 1; alu_zero = 0; PCSource = 2'b01;
        tick();
`ifdef PC_BNE_EN
        chk("bne_branch", pc, 32'hC0);
`else
        chk("bne_branch", pc, 32'h80);
`endif

        // Jump, with simultaneous IR load using pre-edge IR/PC
        PCWriteCond = 0; alu_zero = 0; PCWrite = 1; PCSource = 2'b00;
        alu_result = 32'h30000010; IRWrite = 1; mem_rdata = 32'h08000100;
        tick();
        chk("jmp_setup_pc", pc, 32'h30000010);
        chk("jmp_target", jump_target, 32'h30000400);
        PCSource = 2'b10; mem_rdata = 32'h08000200;
        tick();
        chk("jmp_pc", pc, 32'h30000400);
        chk("jmp_new_instr", instr, 32'h08000200);
        IRWrite = 0;
        tick();
        chk("jmp_second", pc, 32'h30000800);

        // Asynchronous reset mid-cycle, controls ignored while held
        PCSource = 2'b00; alu_result = 32'h44; IRWrite = 1; mem_rdata = 32'hFFFFFFFF;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_mdr", mdr, 32'h0);
        chk("arst_alu_out", alu_out, 32'h0);
        chk("arst_opcode", {26'h0, Op_code}, 32'h0);
        tick();
        chk("arst_hold_pc", pc, 32'h0);
        chk("arst_hold_instr", instr, 32'h0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_pc", pc, 32'h44);
        chk("post_rst_instr", instr, 32'hFFFFFFFF);
        chk("post_rst_opcode", {26'h0, Op_code}, 32'h3F);
        chk("post_rst_imm", imm_sext, 32'hFFFFFFFF);
        chk("post_rst_rd", {27'h0, rd}, 32'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
